// File: rtl/riscv_bus_pkg.sv
// Shared encodings for the core's memory-port arbitration logic.
package riscv_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitResp
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter (bit 0 = IF, bit 1 = DM): round-robin or DM fixed priority.
module rr_arbiter2
    import riscv_bus_pkg::*;
#(
    parameter bit DM_PRIORITY = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    logic last_q;

    always_comb begin
        owner_o = OWN_IF;
        // DM wins when alone, always under fixed priority, or when IF owned the last grant.
        if (req_i[1] && (!req_i[0] || DM_PRIORITY || (last_q == OWN_IF))) begin
            owner_o = OWN_DM;
        end
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = (owner_o == OWN_DM) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= OWN_DM;
        end else if (enable_i && (|req_i)) begin
            last_q <= owner_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and DM: one outstanding transaction, response
// routed back to its owner, timeout turns a dead memory into an error response.
module mem_port_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned DM_PRIORITY    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_err,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_wstrb,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_dm_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [StrbW-1:0]    wstrb_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                if_rvalid_q, dm_rvalid_q, if_err_q, dm_err_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

    logic [1:0]          arb_gnt;
    logic                arb_owner;
    logic                arb_en;
    logic                resp_fire;
    logic                resp_err;

    rr_arbiter2 #(
        .DM_PRIORITY (DM_PRIORITY != 0)
    ) u_arb (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .req_i    ({i_dm_req, i_if_req}),
        .enable_i (arb_en),
        .gnt_o    (arb_gnt),
        .owner_o  (arb_owner)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arb_en    = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        o_mem_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    arb_en  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    cnt_d   = '0;
                    state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                cnt_d = cnt_q + CntW'(1);
                // A response landing on the final counted cycle still beats the timeout.
                if (i_mem_rvalid) begin
                    resp_fire = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (arb_en) begin
                owner_q <= owner_e'(arb_owner);
                if (arb_gnt[1]) begin
                    we_q    <= i_dm_we;
                    addr_q  <= i_dm_addr;
                    wdata_q <= i_dm_wdata;
                    wstrb_q <= i_dm_wstrb;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= i_if_addr;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                end
            end
            if_rvalid_q <= resp_fire && (owner_q == OWN_IF);
            dm_rvalid_q <= resp_fire && (owner_q == OWN_DM);
            if_err_q    <= resp_fire && resp_err && (owner_q == OWN_IF);
            dm_err_q    <= resp_fire && resp_err && (owner_q == OWN_DM);
            if (resp_fire) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= resp_err ? '0 : i_mem_rdata;
                end else begin
                    dm_rdata_q <= resp_err ? '0 : i_mem_rdata;
                end
            end
        end
    end

    assign o_if_gnt    = (state_q == StIssue) && i_mem_ready && (owner_q == OWN_IF);
    assign o_dm_gnt    = (state_q == StIssue) && i_mem_ready && (owner_q == OWN_DM);
    assign o_if_rvalid = if_rvalid_q;
    assign o_dm_rvalid = dm_rvalid_q;
    assign o_if_err    = if_err_q;
    assign o_dm_err    = dm_err_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin (instance 0) and DM-priority (instance 1)
// copies share stimulus and are checked against a transaction-level model each cycle.
module tb_mem_port_arbiter;

    localparam int Tmo = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic [1:0]  if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we, busy;
    logic [31:0] if_rdata [2];
    logic [31:0] dm_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(
            .DM_PRIORITY    (k),
            .TIMEOUT_CYCLES (Tmo)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_if_req     (if_req),
            .i_if_addr    (if_addr),
            .o_if_gnt     (if_gnt[k]),
            .o_if_rvalid  (if_rvalid[k]),
            .o_if_rdata   (if_rdata[k]),
            .o_if_err     (if_err[k]),
            .i_dm_req     (dm_req),
            .i_dm_we      (dm_we),
            .i_dm_addr    (dm_addr),
            .i_dm_wdata   (dm_wdata),
            .i_dm_wstrb   (dm_wstrb),
            .o_dm_gnt     (dm_gnt[k]),
            .o_dm_rvalid  (dm_rvalid[k]),
            .o_dm_rdata   (dm_rdata[k]),
            .o_dm_err     (dm_err[k]),
            .o_mem_req    (mem_req[k]),
            .o_mem_we     (mem_we[k]),
            .o_mem_addr   (mem_addr[k]),
            .o_mem_wdata  (mem_wdata[k]),
            .o_mem_wstrb  (mem_wstrb[k]),
            .i_mem_ready  (mem_ready),
            .i_mem_rvalid (mem_rvalid),
            .i_mem_rdata  (mem_rdata),
            .o_busy       (busy[k])
        );
    end

    // Transaction-level model: phase 0 = free, 1 = request offered, 2 = awaiting answer.
    int          m_phase [2];
    int          m_waited [2];
    logic        m_own [2];
    logic        m_last [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic        m_ifv [2], m_dmv [2], m_ife [2], m_dme [2];
    logic [31:0] m_ifd [2], m_dmd [2];

    function automatic logic pick_dm(input int k);
        return dm_req && (!if_req || k == 1 || m_last[k] == 1'b0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= 0;
                m_waited[k] <= 0;
                m_own[k] <= 1'b0;
                m_last[k] <= 1'b1;
                m_we[k] <= 1'b0;
                m_addr[k] <= 32'h0;
                m_wdata[k] <= 32'h0;
                m_wstrb[k] <= 4'h0;
                m_ifv[k] <= 1'b0;
                m_dmv[k] <= 1'b0;
                m_ife[k] <= 1'b0;
                m_dme[k] <= 1'b0;
                m_ifd[k] <= 32'h0;
                m_dmd[k] <= 32'h0;
            end else begin
                m_ifv[k] <= 1'b0;
                m_dmv[k] <= 1'b0;
                m_ife[k] <= 1'b0;
                m_dme[k] <= 1'b0;
                if (m_phase[k] == 0 && (if_req || dm_req)) begin
                    m_own[k]   <= pick_dm(k);
                    m_last[k]  <= pick_dm(k);
                    m_we[k]    <= pick_dm(k) ? dm_we : 1'b0;
                    m_addr[k]  <= pick_dm(k) ? dm_addr : if_addr;
                    m_wdata[k] <= pick_dm(k) ? dm_wdata : 32'h0;
                    m_wstrb[k] <= pick_dm(k) ? dm_wstrb : 4'h0;
                    m_phase[k] <= 1;
                end else if (m_phase[k] == 1 && mem_ready) begin
                    m_phase[k]  <= 2;
                    m_waited[k] <= 0;
                end else if (m_phase[k] == 2) begin
                    m_waited[k] <= m_waited[k] + 1;
                    if (mem_rvalid || m_waited[k] + 1 == Tmo) begin
                        m_phase[k] <= 0;
                        if (m_own[k]) begin
                            m_dmv[k] <= 1'b1;
                            m_dme[k] <= !mem_rvalid;
                            m_dmd[k] <= mem_rvalid ? mem_rdata : 32'h0;
                        end else begin
                            m_ifv[k] <= 1'b1;
                            m_ife[k] <= !mem_rvalid;
                            m_ifd[k] <= mem_rvalid ? mem_rdata : 32'h0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic         em;
                logic [140:0] exp_v, act_v;
                em = (m_phase[k] == 1);
                exp_v = {em, em ? m_we[k] : 1'b0, em ? m_addr[k] : 32'h0,
                         em ? m_wdata[k] : 32'h0, em ? m_wstrb[k] : 4'h0,
                         em && mem_ready && !m_own[k], m_ifv[k], m_ifd[k], m_ife[k],
                         em && mem_ready && m_own[k], m_dmv[k], m_dmd[k], m_dme[k],
                         m_phase[k] != 0};
                act_v = {mem_req[k], mem_req[k] ? mem_we[k] : 1'b0,
                         mem_req[k] ? mem_addr[k] : 32'h0, mem_req[k] ? mem_wdata[k] : 32'h0,
                         mem_req[k] ? mem_wstrb[k] : 4'h0,
                         if_gnt[k], if_rvalid[k], if_rdata[k], if_err[k],
                         dm_gnt[k], dm_rvalid[k], dm_rdata[k], dm_err[k], busy[k]};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cycle_dut%0d t=%0t: got %h want %h", k, $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Auto memory: answers one cycle after the handshake with the next data word.
    logic        auto_mem;
    logic [31:0] mem_data;

    task automatic step();
        logic hs;
        hs = mem_req[0] && mem_ready;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_rvalid = hs;
            mem_rdata  = hs ? mem_data : 32'h0;
            if (hs) mem_data = mem_data + 32'h11;
        end
    endtask

    task automatic do_reset();
        auto_mem   = 1'b0;
        mem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic rr_seq [$];
        logic exp_seq [5];
        int   fp_if, fp_dm, req_cnt, gnt_cnt, rv_cnt;
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        auto_mem = 1'b0; mem_data = 32'h0;
        do_reset();

        @(negedge clk);
        pin("reset_busy", 32'(busy), 32'h0);
        pin("reset_mem_req", 32'(mem_req), 32'h0);

        // IF alone, one-cycle memory
        if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; auto_mem = 1'b1;
        mem_data = 32'h00500093;
        step();
        @(negedge clk);
        pin("t1_mem_req", 32'(mem_req[0]), 32'h1);
        pin("t1_addr", mem_addr[0], 32'h10);
        pin("t1_we", 32'(mem_we[0]), 32'h0);
        pin("t1_if_gnt", 32'(if_gnt[0]), 32'h1);
        step();
        if_req = 1'b0;
        step();
        @(negedge clk);
        pin("t1_if_rvalid", 32'(if_rvalid[0]), 32'h1);
        pin("t1_if_rdata", if_rdata[0], 32'h00500093);
        pin("t1_if_err", 32'(if_err[0]), 32'h0);
        pin("t1_dm_rvalid", 32'(dm_rvalid[0]), 32'h0);

        // Both requesters held: RR alternates, DM priority always picks DM
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        mem_ready = 1'b1; auto_mem = 1'b1; mem_data = 32'hA0000000;
        fp_if = 0; fp_dm = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (if_gnt[0]) rr_seq.push_back(1'b0);
            if (dm_gnt[0]) rr_seq.push_back(1'b1);
            if (if_gnt[1]) fp_if++;
            if (dm_gnt[1]) fp_dm++;
            step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        pin("t2_rr_grants", rr_seq.size(), 32'd5);
        for (int i = 0; i < 5 && i < rr_seq.size(); i++) begin
            pin($sformatf("t2_rr_order%0d", i), 32'(rr_seq[i]), 32'(exp_seq[i]));
        end
        pin("t3_fp_if_gnt", fp_if, 32'd0);
        pin("t3_fp_dm_gnt", fp_dm, 32'd5);
        repeat (3) step();

        // DM write with memory stalling three cycles
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        dm_wstrb = 4'b0011; mem_ready = 1'b0; auto_mem = 1'b1;
        step();
        req_cnt = 0; gnt_cnt = 0; rv_cnt = 0;
        for (int j = 1; j <= 6; j++) begin
            mem_ready = (j == 4);
            @(negedge clk);
            if (mem_req[0]) begin
                req_cnt++;
                pin("t4_addr", mem_addr[0], 32'h100);
                pin("t4_wdata", mem_wdata[0], 32'hDEADBEEF);
                pin("t4_wstrb", 32'(mem_wstrb[0]), 32'h3);
            end
            if (dm_gnt[0]) begin
                gnt_cnt++;
                pin("t4_gnt_cycle", j, 32'd4);
            end
            if (dm_rvalid[0]) begin
                rv_cnt++;
                pin("t4_rvalid_cycle", j, 32'd6);
            end
            step();
            if (j == 4) dm_req = 1'b0;
        end
        dm_we = 1'b0;
        pin("t4_req_cycles", req_cnt, 32'd4);
        pin("t4_gnt_count", gnt_cnt, 32'd1);
        pin("t4_rvalid_count", rv_cnt, 32'd1);

        // DM read to a dead memory times out after eight wait cycles
        dm_req = 1'b1; dm_addr = 32'h300; mem_ready = 1'b1; auto_mem = 1'b0;
        step();
        dm_req = 1'b0;
        repeat (8) step();
        @(negedge clk);
        pin("t5_busy_last_wait", 32'(busy[0]), 32'h1);
        pin("t5_no_early_rvalid", 32'(dm_rvalid[0]), 32'h0);
        step();
        @(negedge clk);
        pin("t5_dm_rvalid", 32'(dm_rvalid[0]), 32'h1);
        pin("t5_dm_err", 32'(dm_err[0]), 32'h1);
        pin("t5_dm_rdata", dm_rdata[0], 32'h0);
        pin("t5_busy", 32'(busy[0]), 32'h0);
        if_req = 1'b1; if_addr = 32'h44; auto_mem = 1'b1; mem_data = 32'h12345678;
        step();
        if_req = 1'b0;
        step();
        step();
        @(negedge clk);
        pin("t5_if_rvalid", 32'(if_rvalid[0]), 32'h1);
        pin("t5_if_rdata", if_rdata[0], 32'h12345678);
        pin("t5_if_err", 32'(if_err[0]), 32'h0);

        // Reset mid-wait, then a stale memory response
        dm_req = 1'b1; dm_addr = 32'h400; mem_ready = 1'b1; auto_mem = 1'b0;
        step();
        dm_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        pin("t6_busy", 32'(busy), 32'h0);
        pin("t6_dm_rdata", dm_rdata[0], 32'h0);
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        pin("t6_dm_rvalid", 32'(dm_rvalid), 32'h0);
        pin("t6_if_rvalid", 32'(if_rvalid), 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
